seq_multiplier_ctrl: RTL and testbench

Sequencer that time-multiplexes one multiplier_layer shift-add stage over BITS cycles to form a 2*BITS-bit product. It replaces the fully unrolled layer array where area matters, for example in the MLP neuron MAC path. Operands arrive on a valid/ready input channel. The product leaves on a valid/ready output channel.

---
 rtl/mlp_mult_pkg.sv | 17 +
 rtl/multiplier_layer.sv | 27 ++
 rtl/seq_multiplier_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seq_multiplier_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mlp_mult_pkg.sv
// Shared types for the sequential multiplier: FSM state encoding and product width helper.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mlp_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Product of two bits-wide operands needs twice the operand width.
    function automatic int product_w(input int bits);
        return 2 * bits;
    endfunction

endpackage

// File: rtl/multiplier_layer.sv
// One shift-add stage: adds B to the running high half when A_bit is set, then shifts right by one.
// Latency: purely combinational.
// Backpressure: none; the caller sequences it.
// Ports: last (running high half in), B (multiplicand), A_bit (current multiplier bit),
//        result (new high half), out_bit (bit shifted out into the low half).
module multiplier_layer #(
    parameter int bits = 8
) (
    input  logic [bits-1:0] last,
    input  logic [bits-1:0] B,
    input  logic            A_bit,
    output logic [bits-1:0] result,
    output logic            out_bit
);

    logic [bits:0] sum;

    // The adder carry lands in sum[bits] and becomes the top bit of the new
    // high half, so the running product never overflows.
    always_comb begin
        sum = {1'b0, last} + {1'b0, ({bits{A_bit}} & B)};
    end

    assign result  = sum[bits:1];
    assign out_bit = sum[0];

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Sequential BITS x BITS multiplier reusing one multiplier_layer stage over BITS cycles.
// Latency: accept edge, then BITS RUN cycles; product/out_valid registered on RUN->DONE.
// Backpressure: in_ready low in RUN/DONE (in_valid ignored); DONE holds product until out_ready.
// Ports: clk, rst (async active-high), in_valid/in_ready/a_in/b_in operand channel,
//        out_valid/out_ready/product result channel, busy (high while in RUN).
// Build option: define MULT_SIGNED_EN for two's complement operands (sign-magnitude internally).
module seq_multiplier_ctrl
    import mlp_mult_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            a_in,
    input  logic [BITS-1:0]            b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [product_w(BITS)-1:0] product,
    output logic                       busy
);

    localparam int PW    = product_w(BITS);
    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);

    mult_state_t      state_q, state_d;
    logic [BITS-1:0]  a_q, a_d;
    logic [BITS-1:0]  b_q, b_d;
    logic [BITS-1:0]  hi_q, hi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    product_q, product_d;

    logic [BITS-1:0]  layer_result;
    logic             layer_out_bit;
    logic [PW-1:0]    step_product;

`ifdef MULT_SIGNED_EN
    logic             sign_q, sign_d;

    // Magnitude of a two's complement value. The most negative value maps to
    // 2^(BITS-1), which is still representable as an unsigned BITS-bit number.
    function automatic logic [BITS-1:0] magnitude(input logic [BITS-1:0] v);
        return v[BITS-1] ? BITS'(-v) : v;
    endfunction
`endif

    multiplier_layer #(
        .bits (BITS)
    ) u_layer (
        .last    (hi_q),
        .B       (b_q),
        .A_bit   (a_q[0]),
        .result  (layer_result),
        .out_bit (layer_out_bit)
    );

    // Full product as it stands after this cycle's step; on the final step
    // this is the finished result, captured straight into the product register.
    assign step_product = {layer_result, layer_out_bit, a_q[BITS-1:1]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MULT_SIGNED_EN
        sign_d    = sign_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef MULT_SIGNED_EN
                    a_d    = magnitude(a_in);
                    b_d    = magnitude(b_in);
                    sign_d = a_in[BITS-1] ^ b_in[BITS-1];
`else
                    a_d    = a_in;
                    b_d    = b_in;
`endif
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // a_q doubles as the low half: multiplier bits shift out of the
                // bottom while finished product bits shift in at the top.
                hi_d  = layer_result;
                a_d   = {layer_out_bit, a_q[BITS-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
`ifdef MULT_SIGNED_EN
                    product_d = sign_q ? PW'(-step_product) : step_product;
`else
                    product_d = step_product;
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs follow the next state so they are registered and
        // line up with the state they describe.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
`ifdef MULT_SIGNED_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            product_q   <= product_d;
`ifdef MULT_SIGNED_EN
            sign_q      <= sign_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Self-checking bench for seq_multiplier_ctrl (BITS=8): directed vector table, randomized
// operations against an arithmetic reference model, hold/back-pressure and mid-RUN reset.
// Honours MULT_SIGNED_EN for the signed build.
module tb_seq_multiplier_ctrl;

    localparam int BITS = 8;
    localparam int PW   = 2 * BITS;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a_in;
    logic [BITS-1:0] b_in;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   product;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier_ctrl #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        int              hold;
        logic [PW-1:0]   exp_product;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operand values.
    function automatic logic [PW-1:0] ref_mult(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        int sa;
        int sb;
`ifdef MULT_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        return PW'(sa * sb);
    endfunction

    // One full operation. Inputs change and outputs are sampled at negedges.
    // lat counts negedges from the accept edge to first out_valid, so the
    // cycle holding the accept edge is cycle 0 and the product appears in cycle BITS+1.
    task automatic run_op(input string name, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input int hold, input logic [PW-1:0] exp_p);
        int guard;
        int lat;
        bit run_ok;
        bit hold_ok;
        logic [PW-1:0] got;

        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a_in      = a;
        b_in      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        run_ok   = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready || !busy) run_ok = 1'b0;
            // out_ready and in_valid outside DONE/IDLE must be ignored.
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            a_in      = BITS'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        got      = product;
        check({name, " latency"}, 64'(lat), 64'(BITS + 1));
        check({name, " run in_ready=0 busy=1"}, 64'(run_ok), 64'd1);
        check({name, " product"}, 64'(got), 64'(exp_p));
        check({name, " done in_ready/busy"}, {62'd0, in_ready, busy}, 64'd0);

        out_ready = 1'b0;
        hold_ok   = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_in     = BITS'($urandom);
            b_in     = BITS'($urandom);
            @(negedge clk);
            if (!out_valid || product !== got || in_ready || busy) hold_ok = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) check({name, " hold stable"}, 64'(hold_ok), 64'd1);

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " idle after handshake"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    endtask

    vec_t vecs[$];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;

`ifdef MULT_SIGNED_EN
        vecs.push_back('{8'hFD, 8'd5,   0,  16'hFFF1});
        vecs.push_back('{8'h80, 8'h80,  0,  16'h4000});
        vecs.push_back('{8'hFF, 8'd1,   0,  16'hFFFF});
        vecs.push_back('{8'd7,  8'd6,   20, 16'd42});
        vecs.push_back('{8'd127, 8'h80, 0,  16'hC080});
        vecs.push_back('{8'd0,  8'h80,  3,  16'h0000});
`else
        vecs.push_back('{8'd13,  8'd11,  0,  16'h008F});
        vecs.push_back('{8'd255, 8'd255, 0,  16'hFE01});
        vecs.push_back('{8'd0,   8'd200, 0,  16'h0000});
        vecs.push_back('{8'd200, 8'd0,   0,  16'h0000});
        vecs.push_back('{8'd7,   8'd6,   20, 16'd42});
        vecs.push_back('{8'd128, 8'd2,   2,  16'h0100});
`endif

        repeat (3) @(negedge clk);
        check("reset outputs {in_ready,out_valid,busy}", {61'd0, in_ready, out_valid, busy}, 64'b100);
        check("reset product", 64'(product), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp_product);
        end

        // Reset during RUN: abort, no out_valid, then a clean operation.
        a_in     = 8'd9;
        b_in     = 8'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid-run reset outputs", {61'd0, in_ready, out_valid, busy}, 64'b100);
        check("mid-run reset product", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit no_valid;
            no_valid = 1'b1;
            for (int i = 0; i < BITS + 4; i++) begin
                @(negedge clk);
                if (out_valid) no_valid = 1'b0;
            end
            check("no out_valid after abort", 64'(no_valid), 64'd1);
        end
        run_op("after reset", 8'd3, 8'd4, 0, 16'd12);

        // Randomized operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [BITS-1:0] ra;
            logic [BITS-1:0] rb;
            ra = BITS'($urandom);
            rb = BITS'($urandom);
            if (k == 0) ra = '1;
            if (k == 1) rb = {1'b1, {(BITS-1){1'b0}}};
            run_op($sformatf("rand%0d a=%0h b=%0h", k, ra, rb), ra, rb,
                   int'($urandom_range(0, 3)), ref_mult(ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
